// File: rtl/spell_rambus_responder.sv
// spell_rambus_responder: Wishbone responder for the Spell shared-RAM bus.
// Terminates data/code requests in a local word-wide RAM with byte-lane
// writes and a programmable ack latency (LATENCY cycles after acceptance).
// Optional feature macro: SPELL_RAMBUS_CLEAR_EN. When defined, the RAM is
// swept to zero after every reset release while busy is held high.
module spell_rambus_responder #(
  parameter int DEPTH   = 256,  // words, power of two, 2..1024
  parameter int LATENCY = 1     // accept-to-ack cycles, 1..8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [9:0]  wb_addr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [10:0] DEPTH_W  = 11'(DEPTH);
  localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
`ifdef SPELL_RAMBUS_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [9:0]    addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          ack_q;
  logic [31:0]   rdat_q, rdat_d;

  // Request fields used on the edge that enters ACK.
  logic          ent, ent_we, in_range, wr_en;
  logic [3:0]    ent_sel;
  logic [9:0]    ent_addr;
  logic [31:0]   ent_dat;

  // Single RAM write port shared by bus writes and the clear sweep.
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  logic [31:0]   mem [DEPTH];

`ifdef SPELL_RAMBUS_CLEAR_EN
  logic          init_q, init_d;
  logic [AW-1:0] clr_q, clr_d;
`endif

  // Next-state logic, entry-into-ACK decode and RAM port selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    ent      = 1'b0;
    ent_we   = we_q;
    ent_sel  = sel_q;
    ent_addr = addr_q;
    ent_dat  = wdat_q;
`ifdef SPELL_RAMBUS_CLEAR_EN
    init_d   = init_q;
    clr_d    = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SPELL_RAMBUS_CLEAR_EN
        if (init_q) begin
          state_d = S_CLEAR;
          init_d  = 1'b0;
          clr_d   = '0;
        end else
`endif
        if (wb_cyc_i && wb_stb_i) begin
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          addr_d = wb_addr_i;
          wdat_d = wb_dat_i;
          if (LATENCY == 1) begin
            // Acceptance and ACK entry share the same edge: use live inputs.
            state_d  = S_ACK;
            ent      = 1'b1;
            ent_we   = wb_we_i;
            ent_sel  = wb_sel_i;
            ent_addr = wb_addr_i;
            ent_dat  = wb_dat_i;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;        // initiator aborted: no ack, no write
        end else if (cnt_q <= 3'd1) begin
          state_d = S_ACK;
          ent     = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: state_d = S_IDLE;
`ifdef SPELL_RAMBUS_CLEAR_EN
      S_CLEAR: begin
        if (clr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
        else                         clr_d   = clr_q + 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    in_range  = ({1'b0, ent_addr} < DEPTH_W);
    wr_en     = ent && ent_we && wb_cyc_i && wb_stb_i && in_range;
    rdat_d    = (ent && !ent_we && in_range) ? mem[ent_addr[AW-1:0]] : 32'h0;

    mem_we    = wr_en;
    mem_idx   = ent_addr[AW-1:0];
    mem_be    = ent_sel;
    mem_wdata = ent_dat;
`ifdef SPELL_RAMBUS_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_q;
      mem_be    = 4'hF;
      mem_wdata = 32'h0;
    end
`endif
  end

  // Control state, latched request and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef SPELL_RAMBUS_CLEAR_EN
      init_q  <= 1'b1;
      clr_q   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ent;
      rdat_q  <= rdat_d;
`ifdef SPELL_RAMBUS_CLEAR_EN
      init_q  <= init_d;
      clr_q   <= clr_d;
`endif
    end
  end

  // Byte-lane RAM write port.
  // NOTE: the array has no reset; its contents are only defined once written.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
`ifdef SPELL_RAMBUS_CLEAR_EN
  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_spell_rambus_responder.sv
// Testbench for spell_rambus_responder: three instances (LATENCY 1, 3, 4)
// driven by a vector table plus hand-written abort/reset/mid-change sequences.
module tb_spell_rambus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  sel  [3];
  logic [9:0]  addr [3];
  logic [31:0] wdat [3];
  logic        ack  [3];
  logic [31:0] rdat [3];
  logic        busy [3];

  int lat_of [3];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spell_rambus_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clock(clk), .reset_n(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_addr_i(addr[0]), .wb_dat_i(wdat[0]),
    .wb_ack_o(ack[0]), .wb_dat_o(rdat[0]), .busy(busy[0]));

  spell_rambus_responder #(.DEPTH(256), .LATENCY(3)) u_l3 (
    .clock(clk), .reset_n(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_addr_i(addr[1]), .wb_dat_i(wdat[1]),
    .wb_ack_o(ack[1]), .wb_dat_o(rdat[1]), .busy(busy[1]));

  spell_rambus_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clock(clk), .reset_n(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_we_i(we[2]), .wb_sel_i(sel[2]), .wb_addr_i(addr[2]), .wb_dat_i(wdat[2]),
    .wb_ack_o(ack[2]), .wb_dat_o(rdat[2]), .busy(busy[2]));

  typedef struct {
    int          d;
    bit          we;
    logic [3:0]  sel;
    logic [9:0]  addr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full transfer: hold the request until ack (bounded), then drop it and
  // confirm ack lasted one cycle and dat_o returned to zero.
  task automatic xfer(input int d, input bit w, input logic [3:0] s, input logic [9:0] a,
                      input logic [31:0] dt, output logic [31:0] got, output int lat);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = dt;
    lat = 0;
    got = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = k;
        got = rdat[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack[d]), 32'h0);
    check("dat_zero_after_ack", rdat[d], 32'h0);
  endtask

  // Waits (bounded) until no instance reports a clear sweep in progress.
  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!busy[0] && !busy[1] && !busy[2]) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("busy_released", 32'(done), 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          lat;
    int          busy_cnt;

    lat_of = '{1, 3, 4};
    vecs[0]  = '{0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1'b0, 4'hF, 10'h010, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 1'b1, 4'hF, 10'h005, 32'h11223344, 32'h0};
    vecs[3]  = '{0, 1'b1, 4'h5, 10'h005, 32'hAABBCCDD, 32'h0};
    vecs[4]  = '{0, 1'b0, 4'h0, 10'h005, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{0, 1'b1, 4'h0, 10'h005, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{0, 1'b0, 4'h3, 10'h005, 32'h0,        32'h11BB33DD};
    vecs[7]  = '{0, 1'b1, 4'hF, 10'h0FF, 32'h00000077, 32'h0};
    vecs[8]  = '{0, 1'b1, 4'hF, 10'h3FF, 32'h00000099, 32'h0};
    vecs[9]  = '{0, 1'b0, 4'hF, 10'h0FF, 32'h0,        32'h00000077};
    vecs[10] = '{0, 1'b0, 4'hF, 10'h3FF, 32'h0,        32'h00000000};
    vecs[11] = '{0, 1'b1, 4'hA, 10'h0FF, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{0, 1'b0, 4'h1, 10'h0FF, 32'h0,        32'hFF00FF77};
    vecs[13] = '{2, 1'b1, 4'hF, 10'h000, 32'hCAFEBABE, 32'h0};
    vecs[14] = '{2, 1'b1, 4'hF, 10'h100, 32'h12345678, 32'h0};
    vecs[15] = '{2, 1'b0, 4'hF, 10'h100, 32'h0,        32'h00000000};
    vecs[16] = '{2, 1'b0, 4'hF, 10'h000, 32'h0,        32'hCAFEBABE};
    vecs[17] = '{1, 1'b1, 4'hF, 10'h007, 32'h13579BDF, 32'h0};

    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; addr[d] = 10'h0; wdat[d] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ack_%0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("reset_dat_%0d", d), rdat[d], 32'h0);
      check($sformatf("reset_busy_%0d", d), 32'(busy[d]), 32'h0);
    end
    rst_n = 1'b1;

`ifdef SPELL_RAMBUS_CLEAR_EN
    // Read @3 held from reset release: busy for DEPTH cycles, then ack with 0.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; addr[0] = 10'h003;
    busy_cnt = 0;
    got = 32'hFFFFFFFF;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (busy[0]) busy_cnt++;
      if (ack[0]) begin
        got = rdat[0];
        break;
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("clear_busy_cycles", 32'(busy_cnt), 32'd256);
    check("clear_read_zero", got, 32'h0);
    @(posedge clk); #1;
`endif
    wait_idle();

    // Table-driven transfers: latency on every vector, data on reads.
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].d, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].dat, got, lat);
      check($sformatf("latency_v%0d", i), 32'(lat), 32'(lat_of[vecs[i].d]));
      if (!vecs[i].we) check($sformatf("read_v%0d", i), got, vecs[i].exp);
    end

    // L=3 abort: accept write 0x55 @7, drop cyc after one cycle.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 10'h007; wdat[1] = 32'h55;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_no_ack_%0d", k), 32'(ack[1]), 32'h0);
    end
    xfer(1, 1'b0, 4'hF, 10'h007, 32'h0, got, lat);
    check("abort_read_lat", 32'(lat), 32'd3);
    check("abort_read_old", got, 32'h13579BDF);

    // L=4: request fields changed mid-transfer must be ignored.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 10'd20; wdat[2] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    we[2] = 1'b0; sel[2] = 4'h1; addr[2] = 10'd21; wdat[2] = 32'h0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack[2]) begin
        lat = k;
        break;
      end
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    check("midchange_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    xfer(2, 1'b0, 4'hF, 10'd20, 32'h0, got, lat);
    check("midchange_read", got, 32'hA5A5A5A5);

    // L=4: reset pulsed during WAIT kills the write; next request works.
    xfer(2, 1'b1, 4'hF, 10'd9, 32'h0BADF00D, got, lat);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 10'd9; wdat[2] = 32'hCAFEF00D;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    #1;
    check("rst_wait_ack", 32'(ack[2]), 32'h0);
    check("rst_wait_dat", rdat[2], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wait_idle();
    xfer(2, 1'b0, 4'hF, 10'd9, 32'h0, got, lat);
    check("rst_wait_next_lat", 32'(lat), 32'd4);
`ifdef SPELL_RAMBUS_CLEAR_EN
    check("rst_wait_next_read", got, 32'h0);
`else
    check("rst_wait_next_read", got, 32'h0BADF00D);
`endif

    // L=1: reset during ACK clears ack and dat_o at once.
    xfer(0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, got, lat);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h010;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack[0]), 32'h1);
    check("pre_rst_dat", rdat[0], 32'hDEADBEEF);
    rst_n = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    #1;
    check("rst_ack_ack", 32'(ack[0]), 32'h0);
    check("rst_ack_dat", rdat[0], 32'h0);
    do_reset();
    @(posedge clk); #1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
